uart_rx: RTL and testbench

Serial receiver that is the downstream counterpart of `uart_tx`. It takes the asynchronous 8N1 serial line (idle high, one start bit, 8 data bits LSB first, one stop bit, no parity) and synchronizes it into `i_clk`. It recovers each byte by mid-bit sampling at a fixed clocks-per-bit rate and presents the byte with a one-cycle valid strobe. Its bit timing matches `uart_tx`, so `o_uart_tx` can be looped back directly into `i_uart_rx`.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side result bundle of uart_rx: the recovered byte, its one-cycle strobes and the busy flag.
// The receiver drives the master modport and the byte consumer takes the slave modport.
interface uart_rx_if;
   logic [7:0] o_data;
   logic       o_data_valid;
   logic       o_frame_err;
   logic       o_busy;

   modport master (output o_data, output o_data_valid, output o_frame_err, output o_busy);
   modport slave  (input  o_data, input  o_data_valid, input  o_frame_err, input  o_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver that mid-bit samples a two-flop-synchronized line; a strobe appears 2+H+9N edges after the start bit is first seen.
// There is no backpressure: each byte is offered once as a one-cycle o_data_valid strobe and then held.
module uart_rx #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_uart_rx,
   uart_rx_if.master rx
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t           state;
   logic             s1, s2;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       sh;
   logic [7:0]       data_q;
   logic             data_valid_q, frame_err_q, busy_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         s1           <= 1'b1;
         s2           <= 1'b1;
         cnt          <= '0;
         bit_idx      <= '0;
         sh           <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         s1           <= i_uart_rx;
         s2           <= s1;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (!s2) begin
                  state  <= START;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!s2) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     // line went back high before mid-start: treat as noise
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  sh  <= {s2, sh[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (s2) begin
                     // leaving at mid-stop keeps a back-to-back start edge catchable
                     data_q       <= sh;
                     data_valid_q <= 1'b1;
                     state        <= IDLE;
                     busy_q       <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state       <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (!s2) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx.o_data       = data_q;
   assign rx.o_data_valid = data_valid_q;
   assign rx.o_frame_err  = frame_err_q;
   assign rx.o_busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a negedge monitor pops and compares them.
module tb_uart_rx;
   localparam int N = 8;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_uart_rx = 1'b1;

   always #5 i_clk = ~i_clk;

   uart_rx_if rx_if();

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_uart_rx (i_uart_rx),
      .rx        (rx_if)
   );

   typedef struct {
      bit         is_err;
      logic [7:0] dat;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         last_valid_cyc = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation
   always @(negedge i_clk) begin
      if (i_rst_n && (rx_if.o_data_valid || rx_if.o_frame_err)) begin
         exp_t e;
         chk("pulse_overlap", 32'(rx_if.o_data_valid & rx_if.o_frame_err), 32'd0);
         if (rx_if.o_data_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
         end
         if (rx_if.o_frame_err) err_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, rx_if.o_data_valid, rx_if.o_frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 32'(rx_if.o_frame_err), 32'(e.is_err));
            chk("pulse_data", 32'(rx_if.o_data), 32'(e.dat));
         end
      end
   end

   task automatic idle(input int n);
      i_uart_rx = 1'b1;
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic hold_bit(input logic b);
      i_uart_rx = b;
      repeat (N) @(posedge i_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
      hold_bit(stop);
   endtask

   task automatic expect_byte(input logic [7:0] d);
      exp_t e;
      e.is_err = 1'b0;
      e.dat    = d;
      exp_q.push_back(e);
      last_good = d;
   endtask

   task automatic expect_err();
      exp_t e;
      e.is_err = 1'b1;
      e.dat    = last_good;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, v0, e0;
      logic [7:0] aborted;

      // reset values
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_data",  32'(rx_if.o_data), 32'h00);
      chk("rst_valid", 32'(rx_if.o_data_valid), 32'd0);
      chk("rst_err",   32'(rx_if.o_frame_err), 32'd0);
      chk("rst_busy",  32'(rx_if.o_busy), 32'd0);
      i_rst_n = 1'b1;
      idle(4);

      // single byte
      expect_byte(8'h55);
      send_frame(8'h55, 1'b1);
      idle(N);
      chk("single_valid_cnt", 32'(valid_cnt), 32'd1);
      chk("single_err_cnt", 32'(err_cnt), 32'd0);

      // back-to-back frames with no idle gap
      expect_byte(8'hAA);
      send_frame(8'hAA, 1'b1);
      expect_byte(8'h00);
      send_frame(8'h00, 1'b1);
      expect_byte(8'hFF);
      send_frame(8'hFF, 1'b1);
      idle(2 * N);
      chk("b2b_valid_cnt", 32'(valid_cnt), 32'd4);
      chk("b2b_busy_idle", 32'(rx_if.o_busy), 32'd0);

      // 2-cycle glitch: START at e2, false start detected at e(2+H)
      v0 = valid_cnt;
      e0 = err_cnt;
      i_uart_rx = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_uart_rx = 1'b1;
      @(posedge i_clk);
      #1;
      chk("glitch_busy_e2", 32'(rx_if.o_busy), 32'd1);
      repeat (N / 2 - 1) @(posedge i_clk);
      #1;
      chk("glitch_busy_e5", 32'(rx_if.o_busy), 32'd1);
      @(posedge i_clk);
      #1;
      chk("glitch_busy_e6", 32'(rx_if.o_busy), 32'd0);
      idle(2 * N);
      chk("glitch_no_valid", 32'(valid_cnt), 32'(v0));
      chk("glitch_no_err", 32'(err_cnt), 32'(e0));

      // framing error: data held at 0xFF, recovery needs N high samples
      expect_err();
      send_frame(8'h3C, 1'b0);
      chk("ferr_err_cnt", 32'(err_cnt), 32'd1);
      chk("ferr_busy_wait", 32'(rx_if.o_busy), 32'd1);
      i_uart_rx = 1'b1;
      repeat (N + 1) @(posedge i_clk);
      #1;
      chk("ferr_busy_before_n", 32'(rx_if.o_busy), 32'd1);
      @(posedge i_clk);
      #1;
      chk("ferr_busy_after_n", 32'(rx_if.o_busy), 32'd0);
      chk("ferr_data_held", 32'(rx_if.o_data), 32'hFF);
      idle(N);
      expect_byte(8'h81);
      send_frame(8'h81, 1'b1);
      idle(N);
      chk("ferr_recover_cnt", 32'(valid_cnt), 32'd5);

      // reset during data bit 4
      v0 = valid_cnt;
      aborted = 8'hA5;
      hold_bit(1'b0);
      for (int i = 0; i < 4; i++) hold_bit(aborted[i]);
      i_uart_rx = aborted[4];
      repeat (N / 2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      i_uart_rx = 1'b1;
      #1;
      chk("mid_rst_data",  32'(rx_if.o_data), 32'h00);
      chk("mid_rst_valid", 32'(rx_if.o_data_valid), 32'd0);
      chk("mid_rst_err",   32'(rx_if.o_frame_err), 32'd0);
      chk("mid_rst_busy",  32'(rx_if.o_busy), 32'd0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      idle(2 * N);
      chk("mid_rst_no_pulse", 32'(valid_cnt), 32'(v0));
      expect_byte(8'h5A);
      send_frame(8'h5A, 1'b1);
      idle(N);
      chk("post_rst_cnt", 32'(valid_cnt), 32'(v0 + 1));

      // latency: strobe registered at e78, e0 being the edge after t0
      t0 = cyc;
      expect_byte(8'hC3);
      send_frame(8'hC3, 1'b1);
      idle(N);
      chk("latency_e78", 32'(last_valid_cyc - t0), 32'd79);

      idle(2 * N);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("total_valid", 32'(valid_cnt), 32'd7);
      chk("total_err", 32'(err_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
